// File: rtl/fp_operand_loader.sv
// Byte-serial operand assembler feeding the FP ALU: eight bytes -> {A, B, op} with valid/ready.
// Optional mid-frame stall discard is compiled in with `define LOADER_TIMEOUT_EN.
module fp_operand_loader #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_strobe,
    input  logic [1:0]  op_in,
    input  logic        abort,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [1:0]  op_out,
    output logic        out_valid,
    output logic [2:0]  byte_cnt,
    output logic        overrun,
    output logic        timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [1:0] state;
    logic [2:0] wr_idx;
    logic [4:0] wr_pos;
    logic       timeout_hit;

    // A byte landing during a FULL handshake starts the next frame, so it always goes to slot 0.
    assign wr_idx = (state == S_FULL) ? 3'd0 : byte_cnt;
    assign wr_pos = {2'd3 - wr_idx[1:0], 3'b000};

`ifdef LOADER_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] idle_cnt;

    assign timeout_hit = (state == S_COLLECT) && !byte_strobe && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_hit && !abort;
            if (abort || state != S_COLLECT || byte_strobe || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
            out_valid <= 1'b0;
            byte_cnt  <= '0;
            overrun   <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            byte_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (byte_strobe) begin
                        if (wr_idx[2])
                            b_out[wr_pos +: 8] <= byte_in;
                        else
                            a_out[wr_pos +: 8] <= byte_in;
                        if (byte_cnt == 3'd7) begin
                            op_out    <= op_in;
                            out_valid <= 1'b1;
                            byte_cnt  <= '0;
                            state     <= S_FULL;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                            state    <= S_COLLECT;
                        end
                    end else if (timeout_hit) begin
                        byte_cnt <= '0;
                        state    <= S_IDLE;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (byte_strobe) begin
                            if (wr_idx[2])
                                b_out[wr_pos +: 8] <= byte_in;
                            else
                                a_out[wr_pos +: 8] <= byte_in;
                            byte_cnt <= 3'd1;
                            state    <= S_COLLECT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (byte_strobe) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader: table of per-cycle vectors plus reset and stall sequences.
// Timeout expectations follow LOADER_TIMEOUT_EN when defined for the build.
module tb_fp_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_strobe;
    logic [1:0]  op_in;
    logic        abort;
    logic        out_ready;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [1:0]  op_out;
    logic        out_valid;
    logic [2:0]  byte_cnt;
    logic        overrun;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    fp_operand_loader #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_strobe(byte_strobe),
        .op_in(op_in), .abort(abort), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .op_out(op_out), .out_valid(out_valid),
        .byte_cnt(byte_cnt), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        strobe;
        logic [7:0]  b;
        logic [1:0]  op;
        logic        ab;
        logic        rdy;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [1:0]  eop;
        logic        ev;
        logic [2:0]  ecnt;
        logic        eovr;
    } vec_t;

    vec_t tbl[64];
    int   n_vec = 0;

    task automatic add(input logic s, input logic [7:0] b, input logic [1:0] op,
                       input logic ab, input logic rdy, input logic [31:0] ea,
                       input logic [31:0] eb, input logic [1:0] eop, input logic ev,
                       input logic [2:0] ecnt, input logic eovr);
        tbl[n_vec] = '{s, b, op, ab, rdy, ea, eb, eop, ev, ecnt, eovr};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [1:0] eop, input logic ev, input logic [2:0] ecnt,
                           input logic eovr);
        chk({tag, ".a_out"}, a_out, ea);
        chk({tag, ".b_out"}, b_out, eb);
        chk({tag, ".op_out"}, 32'(op_out), 32'(eop));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(ecnt));
        chk({tag, ".overrun"}, 32'(overrun), 32'(eovr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        byte_strobe = 1'b0;
        byte_in     = 8'h00;
        op_in       = 2'd0;
        abort       = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] op);
        byte_strobe = 1'b1;
        byte_in     = b;
        op_in       = op;
        tick();
        idle_inputs();
    endtask

    initial begin
        // Basic pair, handshake
        add(1, 8'h3F, 0, 0, 0, 32'h3F000000, 32'h00000000, 0, 0, 1, 0);
        add(1, 8'h80, 0, 0, 0, 32'h3F800000, 32'h00000000, 0, 0, 2, 0);
        add(1, 8'h00, 0, 0, 0, 32'h3F800000, 32'h00000000, 0, 0, 3, 0);
        add(1, 8'h00, 0, 0, 0, 32'h3F800000, 32'h00000000, 0, 0, 4, 0);
        add(1, 8'h40, 0, 0, 0, 32'h3F800000, 32'h40000000, 0, 0, 5, 0);
        add(1, 8'h00, 0, 0, 0, 32'h3F800000, 32'h40000000, 0, 0, 6, 0);
        add(1, 8'h00, 0, 0, 0, 32'h3F800000, 32'h40000000, 0, 0, 7, 0);
        add(1, 8'h00, 2, 0, 0, 32'h3F800000, 32'h40000000, 2, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 32'h3F800000, 32'h40000000, 2, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 32'h3F800000, 32'h40000000, 2, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 32'h3F800000, 32'h40000000, 2, 0, 0, 0);
        // Second pair, overrun while stalled, abort clears
        add(1, 8'h11, 0, 0, 0, 32'h11800000, 32'h40000000, 2, 0, 1, 0);
        add(1, 8'h22, 0, 0, 0, 32'h11220000, 32'h40000000, 2, 0, 2, 0);
        add(1, 8'h33, 0, 0, 0, 32'h11223300, 32'h40000000, 2, 0, 3, 0);
        add(1, 8'h44, 0, 0, 0, 32'h11223344, 32'h40000000, 2, 0, 4, 0);
        add(1, 8'h55, 0, 0, 0, 32'h11223344, 32'h55000000, 2, 0, 5, 0);
        add(1, 8'h66, 0, 0, 0, 32'h11223344, 32'h55660000, 2, 0, 6, 0);
        add(1, 8'h77, 0, 0, 0, 32'h11223344, 32'h55667700, 2, 0, 7, 0);
        add(1, 8'h88, 1, 0, 0, 32'h11223344, 32'h55667788, 1, 1, 0, 0);
        add(1, 8'hAA, 3, 0, 0, 32'h11223344, 32'h55667788, 1, 1, 0, 1);
        add(1, 8'hBB, 3, 0, 0, 32'h11223344, 32'h55667788, 1, 1, 0, 1);
        add(1, 8'hCC, 3, 0, 0, 32'h11223344, 32'h55667788, 1, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 32'h11223344, 32'h55667788, 1, 0, 0, 0);
        // Third pair, then handshake with simultaneous refill byte
        add(1, 8'h01, 0, 0, 0, 32'h01223344, 32'h55667788, 1, 0, 1, 0);
        add(1, 8'h02, 0, 0, 0, 32'h01023344, 32'h55667788, 1, 0, 2, 0);
        add(1, 8'h03, 0, 0, 0, 32'h01020344, 32'h55667788, 1, 0, 3, 0);
        add(1, 8'h04, 0, 0, 0, 32'h01020304, 32'h55667788, 1, 0, 4, 0);
        add(1, 8'h05, 0, 0, 0, 32'h01020304, 32'h05667788, 1, 0, 5, 0);
        add(1, 8'h06, 0, 0, 0, 32'h01020304, 32'h05067788, 1, 0, 6, 0);
        add(1, 8'h07, 0, 0, 0, 32'h01020304, 32'h05060788, 1, 0, 7, 0);
        add(1, 8'h08, 3, 0, 0, 32'h01020304, 32'h05060708, 3, 1, 0, 0);
        add(1, 8'hC1, 0, 0, 1, 32'hC1020304, 32'h05060708, 3, 0, 1, 0);
        // Abort beats a simultaneous strobe at byte_cnt=3; out_ready ignored when not full
        add(1, 8'hD2, 0, 0, 0, 32'hC1D20304, 32'h05060708, 3, 0, 2, 0);
        add(1, 8'hE3, 0, 0, 0, 32'hC1D2E304, 32'h05060708, 3, 0, 3, 0);
        add(1, 8'hF4, 0, 1, 0, 32'hC1D2E304, 32'h05060708, 3, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 32'hC1D2E304, 32'h05060708, 3, 0, 0, 0);
        add(1, 8'h9A, 0, 0, 0, 32'h9AD2E304, 32'h05060708, 3, 0, 1, 0);

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk_all("reset", 32'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0);
        chk("reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            byte_strobe = tbl[i].strobe;
            byte_in     = tbl[i].b;
            op_in       = tbl[i].op;
            abort       = tbl[i].ab;
            out_ready   = tbl[i].rdy;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eop,
                    tbl[i].ev, tbl[i].ecnt, tbl[i].eovr);
            chk($sformatf("vec%0d.timeout", i), 32'(timeout), 32'd0);
        end
        idle_inputs();

        // Reset mid-frame, then a clean pair
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0); send(8'h9A, 0);
        rst = 1'b1;
        byte_strobe = 1'b1;
        byte_in     = 8'hEE;
        abort       = 1'b1;
        out_ready   = 1'b1;
        tick();
        idle_inputs();
        rst = 1'b0;
        chk_all("midrst", 32'h0, 32'h0, 2'd0, 1'b0, 3'd0, 1'b0);
        chk("midrst.timeout", 32'(timeout), 32'd0);
        send(8'h40, 0); send(8'h49, 0); send(8'h0F, 0); send(8'hDB, 0);
        send(8'hC0, 0); send(8'h00, 0); send(8'h00, 0);
        chk_all("fresh7", 32'h40490FDB, 32'hC0000000, 2'd0, 1'b0, 3'd7, 1'b0);
        send(8'h00, 1);
        chk_all("fresh8", 32'h40490FDB, 32'hC0000000, 2'd1, 1'b1, 3'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        idle_inputs();
        chk_all("fresh_hs", 32'h40490FDB, 32'hC0000000, 2'd1, 1'b0, 3'd0, 1'b0);

        // Stalled partial frame: 2 bytes then idle cycles
        send(8'hA1, 0); send(8'hB2, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
`ifdef LOADER_TIMEOUT_EN
            chk($sformatf("stall%0d.byte_cnt", k), 32'(byte_cnt), (k >= 4) ? 32'd0 : 32'd2);
            chk($sformatf("stall%0d.timeout", k), 32'(timeout), (k == 4) ? 32'd1 : 32'd0);
`else
            chk($sformatf("stall%0d.byte_cnt", k), 32'(byte_cnt), 32'd2);
            chk($sformatf("stall%0d.timeout", k), 32'(timeout), 32'd0);
`endif
        end

        // Three idle cycles then a byte must not time out
        abort = 1'b1;
        tick();
        idle_inputs();
        chk("pre_gap.byte_cnt", 32'(byte_cnt), 32'd0);
        send(8'h01, 0); send(8'h02, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("gap%0d.timeout", k), 32'(timeout), 32'd0);
        end
        send(8'h03, 0);
        chk("gap_byte.byte_cnt", 32'(byte_cnt), 32'd3);
        chk("gap_byte.timeout", 32'(timeout), 32'd0);
        chk("gap_byte.a_out", a_out, 32'h010203DB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Byte-serial operand assembler sitting directly upstream of the 32-bit floating-point ALU. Collects eight bytes from the 8-bit dedicated input bus, forms operand A and operand B (IEEE-754 single, MSB byte first), captures the opcode, and presents the pair to the ALU with a valid/ready handshake. Holds the completed pair stable until the ALU accepts it. Flags dropped bytes and, optionally, stalled partial frames.

## Interface

Parameters:
- TIMEOUT_CYC, 255: idle cycles allowed mid-frame before discard; used only with LOADER_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- byte_in  in  8  operand byte
- byte_strobe  in  1  byte_in valid this cycle; one byte per high cycle
- op_in  in  2  ALU opcode; sampled with the 8th byte only
- abort  in  1  discard any partial or completed frame
- out_ready  in  1  ALU accepts pair this cycle
- a_out  out  32  operand A
- b_out  out  32  operand B
- op_out  out  2  captured opcode
- out_valid  out  1  pair complete and stable
- byte_cnt  out  3  bytes collected in current frame (0..7)
- overrun  out  1  sticky: a byte was dropped while FULL
- timeout  out  1  one-cycle pulse: partial frame discarded by timeout (constant 0 without LOADER_TIMEOUT_EN)

## Operation

- States: IDLE (byte_cnt=0), COLLECT (byte_cnt 1..7), FULL (out_valid=1).
- IDLE/COLLECT + byte_strobe: byte stored at index byte_cnt; byte_cnt increments. Index 0..3 → a_out[31:24], [23:16], [15:8], [7:0]; index 4..7 → same order into b_out.
- Index 7 accepted: op_out <= op_in, state FULL, byte_cnt wraps to 0.
- FULL: a_out, b_out, op_out frozen. out_ready high → handshake completes, out_valid falls next cycle, state IDLE.
- FULL + byte_strobe, no out_ready: byte dropped, overrun set. Stays set until rst or abort.
- FULL + out_ready + byte_strobe same cycle: handshake completes AND byte stored as index 0 of the next frame → state COLLECT, byte_cnt=1. overrun not set.
- abort (any state): byte_cnt=0, out_valid=0, overrun=0, state IDLE. abort wins over simultaneous byte_strobe (byte dropped) and over out_ready (no handshake counted).
- out_ready ignored outside FULL.
- a_out/b_out keep last written contents when not FULL; only valid while out_valid=1.
- Reset values: a_out=0, b_out=0, op_out=0, out_valid=0, byte_cnt=0, overrun=0, timeout=0; state IDLE. Reset mid-frame discards all bytes; reset has priority over every input.

## Timing

- All outputs registered; no combinational input→output paths.
- Byte with strobe at cycle N appears in a_out/b_out and byte_cnt from cycle N+1.
- 8th byte at cycle N → out_valid=1 from cycle N+1.
- out_ready at cycle M with out_valid=1 → out_valid=0 in cycle M+1 (unless refilled per the simultaneous rule, which still drops out_valid for at least 7 cycles).
- Peak throughput: one pair per 8 cycles when out_ready held high.

## Configuration

- LOADER_TIMEOUT_EN defined: 8-bit idle counter runs in COLLECT, cleared by every accepted byte and on leaving COLLECT. Reaching TIMEOUT_CYC idle cycles → byte_cnt=0, state IDLE, timeout pulses high for exactly one cycle (the cycle after discard). IDLE and FULL never time out.
- Not defined: no counter; partial frames wait indefinitely; timeout tied 0.

## Test plan

- Bytes 3F 80 00 00 40 00 00 00 on consecutive cycles, op_in=2 on last → a_out=3F800000, b_out=40000000, op_out=2, out_valid high cycle after 8th byte; out_ready one cycle → out_valid low next cycle, byte_cnt=0.
- Full frame, out_ready held low, 3 further strobes → pair unchanged, overrun=1; then abort → overrun=0, out_valid=0, byte_cnt=0.
- FULL with out_ready and strobe (byte C1) same cycle → handshake counted, byte_cnt=1, a_out[31:24]=C1, overrun=0.
- 5 bytes then rst high one cycle → all outputs at reset values; next 8 bytes form a correct fresh pair.
- abort and byte_strobe same cycle at byte_cnt=3 → byte_cnt=0, byte dropped.
- With LOADER_TIMEOUT_EN, TIMEOUT_CYC=4: 2 bytes then 4 idle cycles → byte_cnt=0, single-cycle timeout pulse; 3 idle cycles then byte → no timeout, byte_cnt=3. Without macro: timeout stays 0, byte_cnt held at 2.
